vc_input_port: RTL and testbench

- Multi-VC input port for the dynamic router. It replaces the single-VC buffer with NUM_VC independent virtual channels behind one physical link.
- Each VC has its own flit FIFO and packet-level state machine: idle, waiting for output VC, active.
- Incoming flits are demultiplexed by VC id. Active VCs are arbitrated round-robin onto one switch-request output.
- Upstream credits are returned per VC on every dequeue.

---
 rtl/vc_input_port.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vc_input_port.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_port.sv
// Multi-VC input port: demultiplexes incoming flits into per-VC FIFOs,
// runs a packet-level FSM per VC (IDLE -> WAIT_OVC -> ACTIVE), and
// arbitrates ready VCs round-robin onto a single switch request.
// Upstream credits and output-VC releases are registered one-cycle pulses.
module vc_input_port #(
    parameter int FLIT_SIZE  = 32,
    parameter int HEADER_LEN = 2,
    parameter int ROUTE_LEN  = 3,
    parameter int NUM_VC     = 4,
    parameter int VC_DEPTH   = 8,
    localparam int VCW       = $clog2(NUM_VC),
    localparam int CW        = $clog2(VC_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FLIT_SIZE-1:0]        flit_in,
    input  logic                        valid_in,
    input  logic [VCW-1:0]              vc_in,
    input  logic [ROUTE_LEN-1:0]        route_in,
    output logic [NUM_VC-1:0]           ovc_req,
    output logic [NUM_VC*ROUTE_LEN-1:0] ovc_req_route,
    input  logic [NUM_VC-1:0]           ovc_grant,
    input  logic [NUM_VC*VCW-1:0]       ovc_id,
    input  logic [NUM_VC-1:0]           credit_ok,
    output logic [FLIT_SIZE-1:0]        flit_out,
    output logic [ROUTE_LEN-1:0]        route_out,
    output logic [VCW-1:0]              ovc_out,
    output logic [VCW-1:0]              vc_out,
    output logic                        valid_out,
    input  logic                        sw_ready,
    output logic [NUM_VC-1:0]           credit_out,
    output logic [NUM_VC-1:0]           ovc_release,
    output logic [NUM_VC*CW-1:0]        vc_free,
    output logic [NUM_VC-1:0]           vc_idle,
    output logic                        overflow_err,
    output logic                        protocol_err
);

    localparam int DW = ROUTE_LEN + FLIT_SIZE;   // stored entry: {route, flit}
    localparam int AW = CW - 1;                  // FIFO pointer width

    localparam logic [HEADER_LEN-1:0] TYPE_BODY   = HEADER_LEN'(0);
    localparam logic [HEADER_LEN-1:0] TYPE_HEAD   = HEADER_LEN'(1);
    localparam logic [HEADER_LEN-1:0] TYPE_TAIL   = HEADER_LEN'(2);
    localparam logic [HEADER_LEN-1:0] TYPE_SINGLE = HEADER_LEN'(3);

    localparam logic [CW-1:0] DEPTH_C = CW'(VC_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OVC = 2'd1,
        ST_ACTIVE   = 2'd2
    } vc_state_t;

    // Per-VC views gathered for the arbiter and output muxes
    logic [NUM_VC-1:0]                eligible;
    logic [NUM_VC-1:0]                deq_vc;
    logic [NUM_VC-1:0]                drop_vc;
    logic [NUM_VC-1:0]                release_vc;
    logic [NUM_VC-1:0]                proto_vc;
    logic [NUM_VC-1:0]                ovf_vc;
    logic [NUM_VC-1:0][FLIT_SIZE-1:0] head_flit;
    logic [NUM_VC-1:0][ROUTE_LEN-1:0] head_route;
    logic [NUM_VC-1:0][VCW-1:0]       ovc_all;

    // Arbiter state
    logic [VCW-1:0] ptr_reg;
    logic [VCW-1:0] lock_vc_reg;
    logic           lock_reg;
    logic [VCW-1:0] sel_vc;
    logic           sel_valid;
    logic           accept;

    logic [NUM_VC-1:0] credit_out_reg;
    logic [NUM_VC-1:0] ovc_release_reg;
    logic              overflow_err_reg;
    logic              protocol_err_reg;

    assign accept = sel_valid && sw_ready;

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : gen_vc
            logic [DW-1:0]         mem_reg [VC_DEPTH];
            logic [AW-1:0]         wr_ptr_reg;
            logic [AW-1:0]         rd_ptr_reg;
            logic [CW-1:0]         count_reg;
            vc_state_t             state_reg;
            vc_state_t             state_next;
            logic [VCW-1:0]        ovc_reg;
            logic                  first_reg;
            logic                  wr_hit;
            logic                  wr_en;
            logic                  rd_en;
            logic                  not_empty;
            logic [HEADER_LEN-1:0] head_type;
            logic                  head_starts;
            logic                  head_ends;
            logic                  release_c;
            logic                  proto_c;
            logic                  drop_c;

            assign wr_hit      = valid_in && (vc_in == VCW'(gi));
            assign wr_en       = wr_hit && (count_reg != DEPTH_C);
            assign ovf_vc[gi]  = wr_hit && (count_reg == DEPTH_C);
            assign not_empty   = (count_reg != '0);
            assign head_type   = mem_reg[rd_ptr_reg][FLIT_SIZE-1 -: HEADER_LEN];
            assign head_starts = (head_type == TYPE_HEAD) || (head_type == TYPE_SINGLE);
            assign head_ends   = (head_type == TYPE_TAIL) || (head_type == TYPE_SINGLE);
            assign rd_en       = deq_vc[gi] || drop_c;

            assign head_flit[gi]  = mem_reg[rd_ptr_reg][FLIT_SIZE-1:0];
            assign head_route[gi] = mem_reg[rd_ptr_reg][DW-1:FLIT_SIZE];
            assign ovc_all[gi]    = ovc_reg;
            assign eligible[gi]   = (state_reg == ST_ACTIVE) && not_empty && credit_ok[gi];
            assign drop_vc[gi]    = drop_c;
            assign release_vc[gi] = release_c;
            assign proto_vc[gi]   = proto_c;

            assign ovc_req[gi]    = (state_reg == ST_WAIT_OVC);
            assign ovc_req_route[gi*ROUTE_LEN +: ROUTE_LEN] =
                (state_reg == ST_WAIT_OVC) ? head_route[gi] : '0;
            assign vc_idle[gi]    = (state_reg == ST_IDLE);
            assign vc_free[gi*CW +: CW] = DEPTH_C - count_reg;

            // Flit storage: write at the tail, no reset needed for data
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem_reg[wr_ptr_reg] <= {route_in, flit_in};
                end
            end

            // FIFO pointers and occupancy; a full FIFO never accepts, even on a same-cycle pop
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    case ({wr_en, rd_en})
                        2'b10:   count_reg <= count_reg + CW'(1);
                        2'b01:   count_reg <= count_reg - CW'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Packet FSM next-state and event decode
            always_comb begin
                state_next = state_reg;
                release_c  = 1'b0;
                proto_c    = 1'b0;
                drop_c     = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (not_empty) begin
                            if (head_starts) begin
                                state_next = ST_WAIT_OVC;
                            end else begin
                                // Orphan body/tail: discard it and return its credit
                                drop_c  = 1'b1;
                                proto_c = 1'b1;
                            end
                        end
                    end
                    ST_WAIT_OVC: begin
                        if (ovc_grant[gi]) state_next = ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (deq_vc[gi]) begin
                            if (head_starts && !first_reg) proto_c = 1'b1;
                            if (head_ends) begin
                                release_c = 1'b1;
                                // Only flits already buffered decide; a same-cycle write is not counted
                                state_next = (count_reg > CW'(1)) ? ST_WAIT_OVC : ST_IDLE;
                            end
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            // Packet FSM state, latched downstream VC and first-flit marker
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= ST_IDLE;
                    ovc_reg   <= '0;
                    first_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    if ((state_reg == ST_WAIT_OVC) && ovc_grant[gi]) begin
                        ovc_reg   <= ovc_id[gi*VCW +: VCW];
                        first_reg <= 1'b1;
                    end else if (deq_vc[gi]) begin
                        first_reg <= 1'b0;
                    end
                end
            end

            assign deq_vc[gi] = accept && (sel_vc == VCW'(gi));
        end
    endgenerate

    // Round-robin pick starting after the last served VC; a held lock overrides the scan
    always_comb begin
        int idx;
        idx       = 0;
        sel_vc    = lock_reg ? lock_vc_reg : ptr_reg;
        sel_valid = lock_reg;
        if (!lock_reg) begin
            for (int i = 1; i <= NUM_VC; i++) begin
                idx = int'(ptr_reg) + i;
                if (idx >= NUM_VC) idx = idx - NUM_VC;
                if (!sel_valid && eligible[idx]) begin
                    sel_vc    = VCW'(idx);
                    sel_valid = 1'b1;
                end
            end
        end
    end

    // Arbiter pointer and lock: a stalled selection stays put until the switch takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg     <= VCW'(NUM_VC - 1);
            lock_reg    <= 1'b0;
            lock_vc_reg <= '0;
        end else if (accept) begin
            ptr_reg  <= sel_vc;
            lock_reg <= 1'b0;
        end else if (sel_valid) begin
            lock_reg    <= 1'b1;
            lock_vc_reg <= sel_vc;
        end
    end

    // Credit/release pulses and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_out_reg   <= '0;
            ovc_release_reg  <= '0;
            overflow_err_reg <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            credit_out_reg   <= deq_vc | drop_vc;
            ovc_release_reg  <= release_vc;
            overflow_err_reg <= overflow_err_reg | (|ovf_vc);
            protocol_err_reg <= protocol_err_reg | (|proto_vc);
        end
    end

    assign valid_out    = sel_valid;
    assign flit_out     = sel_valid ? head_flit[sel_vc]  : '0;
    assign route_out    = sel_valid ? head_route[sel_vc] : '0;
    assign ovc_out      = sel_valid ? ovc_all[sel_vc]    : '0;
    assign vc_out       = sel_valid ? sel_vc             : '0;
    assign credit_out   = credit_out_reg;
    assign ovc_release  = ovc_release_reg;
    assign overflow_err = overflow_err_reg;
    assign protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_vc_input_port.sv
// Directed bench for vc_input_port with a scoreboard of expected switch outputs.
module tb_vc_input_port;

    localparam int FS  = 32;
    localparam int RL  = 3;
    localparam int NV  = 4;
    localparam int VCW = 2;
    localparam int CW  = 4;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_SGL  = 2'b11;

    logic              clk;
    logic              rst;
    logic [FS-1:0]     flit_in;
    logic              valid_in;
    logic [VCW-1:0]    vc_in;
    logic [RL-1:0]     route_in;
    logic [NV-1:0]     ovc_req;
    logic [NV*RL-1:0]  ovc_req_route;
    logic [NV-1:0]     ovc_grant;
    logic [NV*VCW-1:0] ovc_id;
    logic [NV-1:0]     credit_ok;
    logic [FS-1:0]     flit_out;
    logic [RL-1:0]     route_out;
    logic [VCW-1:0]    ovc_out;
    logic [VCW-1:0]    vc_out;
    logic              valid_out;
    logic              sw_ready;
    logic [NV-1:0]     credit_out;
    logic [NV-1:0]     ovc_release;
    logic [NV*CW-1:0]  vc_free;
    logic [NV-1:0]     vc_idle;
    logic              overflow_err;
    logic              protocol_err;

    typedef struct packed {
        logic [FS-1:0]  flit;
        logic [RL-1:0]  route;
        logic [VCW-1:0] ovc;
        logic [VCW-1:0] vc;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    vc_input_port dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in), .vc_in(vc_in),
        .route_in(route_in), .ovc_req(ovc_req), .ovc_req_route(ovc_req_route),
        .ovc_grant(ovc_grant), .ovc_id(ovc_id), .credit_ok(credit_ok),
        .flit_out(flit_out), .route_out(route_out), .ovc_out(ovc_out), .vc_out(vc_out),
        .valid_out(valid_out), .sw_ready(sw_ready), .credit_out(credit_out),
        .ovc_release(ovc_release), .vc_free(vc_free), .vc_idle(vc_idle),
        .overflow_err(overflow_err), .protocol_err(protocol_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FS-1:0] mkflit(input logic [1:0] ft, input int pl);
        return {ft, 30'(pl)};
    endfunction

    function automatic exp_t mkexp(input logic [FS-1:0] f, input int rt, input int ovc, input int vc);
        exp_t e;
        e.flit  = f;
        e.route = RL'(rt);
        e.ovc   = VCW'(ovc);
        e.vc    = VCW'(vc);
        return e;
    endfunction

    // One clock: settle inputs, score any flit the switch takes at this edge, then
    // return on the falling edge with registered outputs updated.
    task automatic clk_step();
        exp_t e;
        #1;
        if (!rst && valid_out && sw_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_flit", {flit_out, route_out, ovc_out, vc_out}, 64'hDEAD);
            end else begin
                e = sb_q.pop_front();
                check("sb_flit", {flit_out, route_out, ovc_out, vc_out}, e);
                $display("[TB] out vc=%0d ovc=%0d route=%0d flit=%08h", vc_out, ovc_out, route_out, flit_out);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int vc, input logic [FS-1:0] f, input int rt);
        flit_in  = f;
        vc_in    = VCW'(vc);
        route_in = RL'(rt);
        valid_in = 1'b1;
        clk_step();
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk_step();
        clk_step();
        rst = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        logic [FS-1:0] f;
        rst = 1'b1; flit_in = '0; valid_in = 1'b0; vc_in = '0; route_in = '0;
        ovc_grant = '0; ovc_id = '0; credit_ok = '1; sw_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_ovc_req",    ovc_req, 0);
        check("rst_valid_out",  valid_out, 0);
        check("rst_credit_out", credit_out, 0);
        check("rst_release",    ovc_release, 0);
        check("rst_vc_idle",    vc_idle, 4'hF);
        check("rst_vc_free",    vc_free, 16'h8888);
        check("rst_errs",       {overflow_err, protocol_err}, 0);

        // Single-flit packet on VC2
        f = mkflit(T_SGL, 'h123);
        sb_q.push_back(mkexp(f, 3, 1, 2));
        send(2, f, 3);
        check("sgl_req_early", ovc_req, 0);
        clk_step();
        check("sgl_req",       ovc_req, 4'b0100);
        check("sgl_req_route", ovc_req_route[2*RL +: RL], 3);
        ovc_grant = 4'b0100; ovc_id = '0; ovc_id[2*VCW +: VCW] = 2'd1;
        clk_step();
        ovc_grant = '0;
        #1;
        check("sgl_valid",  valid_out, 1);
        check("sgl_vc_ovc", {vc_out, ovc_out}, {2'd2, 2'd1});
        clk_step();
        check("sgl_credit",  credit_out, 4'b0100);
        check("sgl_release", ovc_release, 4'b0100);
        check("sgl_idle",    vc_idle, 4'hF);
        check("sgl_free",    vc_free, 16'h8888);
        check("sgl_perr",    protocol_err, 0);
        clk_step();
        check("sgl_pulse_end", {credit_out, ovc_release}, 0);

        // HEAD-BODY-BODY-TAIL on VC0 with another HEAD queued behind
        do_reset();
        sb_q.push_back(mkexp(mkflit(T_HEAD, 'h10), 1, 2, 0));
        sb_q.push_back(mkexp(mkflit(T_BODY, 'h11), 1, 2, 0));
        sb_q.push_back(mkexp(mkflit(T_BODY, 'h12), 1, 2, 0));
        sb_q.push_back(mkexp(mkflit(T_TAIL, 'h13), 1, 2, 0));
        send(0, mkflit(T_HEAD, 'h10), 1);
        send(0, mkflit(T_BODY, 'h11), 1);
        send(0, mkflit(T_BODY, 'h12), 1);
        send(0, mkflit(T_TAIL, 'h13), 1);
        send(0, mkflit(T_HEAD, 'h20), 6);
        check("pkt_req",  ovc_req, 4'b0001);
        check("pkt_free", vc_free[0 +: CW], 3);
        ovc_grant = 4'b0001; ovc_id = '0; ovc_id[0 +: VCW] = 2'd2;
        clk_step();
        ovc_grant = '0;
        for (int i = 0; i < 4; i++) clk_step();
        check("pkt_sb_empty",  sb_q.size(), 0);
        check("pkt_rewait",    ovc_req, 4'b0001);
        check("pkt_req_route", ovc_req_route[0 +: RL], 6);
        check("pkt_release",   ovc_release, 4'b0001);
        check("pkt_not_idle",  vc_idle, 4'b1110);
        check("pkt_valid_off", valid_out, 0);
        check("pkt_free_after", vc_free[0 +: CW], 7);

        // Round-robin over VCs 0, 1, 3
        do_reset();
        send(0, mkflit(T_HEAD, 'h30), 0);
        send(0, mkflit(T_TAIL, 'h31), 0);
        send(1, mkflit(T_HEAD, 'h40), 2);
        send(1, mkflit(T_TAIL, 'h41), 2);
        send(3, mkflit(T_HEAD, 'h50), 4);
        send(3, mkflit(T_TAIL, 'h51), 4);
        check("rr_req", ovc_req, 4'b1011);
        sb_q.push_back(mkexp(mkflit(T_HEAD, 'h30), 0, 3, 0));
        sb_q.push_back(mkexp(mkflit(T_HEAD, 'h40), 2, 2, 1));
        sb_q.push_back(mkexp(mkflit(T_HEAD, 'h50), 4, 0, 3));
        sb_q.push_back(mkexp(mkflit(T_TAIL, 'h31), 0, 3, 0));
        sb_q.push_back(mkexp(mkflit(T_TAIL, 'h41), 2, 2, 1));
        sb_q.push_back(mkexp(mkflit(T_TAIL, 'h51), 4, 0, 3));
        ovc_grant = 4'b1011;
        ovc_id = {2'd0, 2'd0, 2'd2, 2'd3};
        clk_step();
        ovc_grant = '0;
        for (int i = 0; i < 6; i++) clk_step();
        check("rr_sb_empty", sb_q.size(), 0);
        check("rr_idle",     vc_idle, 4'hF);
        check("rr_valid_off", valid_out, 0);

        // Backpressure with credit_ok toggling
        do_reset();
        f = mkflit(T_SGL, 'h77);
        sb_q.push_back(mkexp(f, 5, 3, 1));
        send(1, f, 5);
        clk_step();
        check("bp_req", ovc_req, 4'b0010);
        sw_ready = 1'b0;
        ovc_grant = 4'b0010; ovc_id = '0; ovc_id[1*VCW +: VCW] = 2'd3;
        clk_step();
        ovc_grant = '0;
        #1;
        check("bp_c0", {valid_out, flit_out, route_out, ovc_out, vc_out}, {1'b1, f, 3'd5, 2'd3, 2'd1});
        clk_step();
        credit_ok[1] = 1'b0;
        #1;
        check("bp_c1", {valid_out, flit_out, route_out, ovc_out, vc_out}, {1'b1, f, 3'd5, 2'd3, 2'd1});
        check("bp_c1_credit", credit_out, 0);
        clk_step();
        credit_ok = '1;
        #1;
        check("bp_c2", {valid_out, flit_out, vc_out}, {1'b1, f, 2'd1});
        check("bp_c2_credit", credit_out, 0);
        clk_step();
        credit_ok[1] = 1'b0;
        sw_ready = 1'b1;
        #1;
        check("bp_c3_valid", valid_out, 1);
        clk_step();
        credit_ok = '1;
        check("bp_credit",   credit_out, 4'b0010);
        check("bp_sb_empty", sb_q.size(), 0);
        check("bp_valid_off", valid_out, 0);
        clk_step();
        check("bp_one_pulse", credit_out, 0);

        // Overflow on VC1
        do_reset();
        send(1, mkflit(T_HEAD, 'h80), 1);
        for (int i = 1; i < 8; i++) send(1, mkflit(T_BODY, 'h80 + i), 1);
        check("ovf_free8", vc_free[1*CW +: CW], 0);
        check("ovf_err_pre", overflow_err, 0);
        send(1, mkflit(T_BODY, 'h88), 1);
        check("ovf_err",    overflow_err, 1);
        check("ovf_free",   vc_free, 16'h8808);
        check("ovf_req",    ovc_req, 4'b0010);
        check("ovf_perr",   protocol_err, 0);

        // Orphan BODY into idle VC3, then reset mid-packet
        do_reset();
        send(3, mkflit(T_BODY, 'h90), 2);
        clk_step();
        check("prot_credit", credit_out, 4'b1000);
        check("prot_err",    protocol_err, 1);
        check("prot_free",   vc_free, 16'h8888);
        check("prot_idle",   vc_idle, 4'hF);
        send(0, mkflit(T_HEAD, 'hA0), 1);
        clk_step();
        sw_ready = 1'b0;
        ovc_grant = 4'b0001; ovc_id = '0;
        clk_step();
        ovc_grant = '0;
        #1;
        check("mid_valid",  valid_out, 1);
        check("mid_sticky", protocol_err, 1);
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        sw_ready = 1'b1;
        check("mrst_outs", {ovc_req, valid_out, credit_out, ovc_release}, 0);
        check("mrst_idle", vc_idle, 4'hF);
        check("mrst_free", vc_free, 16'h8888);
        check("mrst_errs", {overflow_err, protocol_err}, 0);
        clk_step();
        check("mrst_stay", valid_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
